// File: rtl/act_enc_pkg.sv
// Shared defaults and FSM state type for the sparse activation encoder.
// Contents:
//   DefBw, DefNvec, DefLanes, DefIdxw : default geometry of the encoder
//   state_e                           : encoder FSM states
package act_enc_pkg;

  localparam int unsigned DefBw    = 4;
  localparam int unsigned DefNvec  = 4;
  localparam int unsigned DefLanes = 2;
  localparam int unsigned DefIdxw  = $clog2(DefNvec);

  typedef enum logic {
    StIdle,
    StEmit
  } state_e;

endpackage

// File: rtl/nz_pick2.sv
// Combinational picker: returns the two lowest set bit positions of a mask.
// Ports:
//   i_mask : NVEC-bit mask of candidate positions
//   o_idx0 : lowest set position          o_vld0 : o_idx0 is meaningful
//   o_idx1 : second-lowest set position   o_vld1 : o_idx1 is meaningful
// Unused pick indexes are driven to 0.
module nz_pick2 #(
  parameter int unsigned NVEC = 4,
  parameter int unsigned IDXW = $clog2(NVEC)
) (
  input  logic [NVEC-1:0] i_mask,
  output logic [IDXW-1:0] o_idx0,
  output logic            o_vld0,
  output logic [IDXW-1:0] o_idx1,
  output logic            o_vld1
);

  always_comb begin
    o_idx0 = '0;
    o_vld0 = 1'b0;
    o_idx1 = '0;
    o_vld1 = 1'b0;
    // Ascending scan: first hit fills pick 0, second hit fills pick 1.
    for (int i = 0; i < NVEC; i++) begin
      if (i_mask[i] && !o_vld0) begin
        o_idx0 = IDXW'(i);
        o_vld0 = 1'b1;
      end else if (i_mask[i] && !o_vld1) begin
        o_idx1 = IDXW'(i);
        o_vld1 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/act_sparse_encoder.sv
// Sparse activation encoder: accepts a dense vector of NVEC activations and
// emits its nonzero elements, LANES per beat, in ascending position order.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   in_valid / in_ready / in_act: dense vector handshake, element i at [i*BW +: BW]
//   out_valid / out_ready       : compressed beat handshake
//   out_activation              : LANES nonzero values, lane 0 lowest position
//   out_act_index               : dense position of each lane's value
//   out_lane_valid              : per-lane valid
//   out_last                    : final beat of the current vector
//   out_nz_count                : total nonzero count of the current vector
// The picker datapath serves two lanes; lanes beyond the second stay idle.
// Outputs are decoded from registered state only (vector, remaining mask,
// count, FSM state); in_ready alone sees out_ready combinationally.
module act_sparse_encoder
  import act_enc_pkg::*;
#(
  parameter int unsigned BW    = DefBw,
  parameter int unsigned NVEC  = DefNvec,
  parameter int unsigned LANES = DefLanes,
  parameter int unsigned IDXW  = $clog2(NVEC)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NVEC*BW-1:0]    in_act,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*BW-1:0]   out_activation,
  output logic [LANES*IDXW-1:0] out_act_index,
  output logic [LANES-1:0]      out_lane_valid,
  output logic                  out_last,
  output logic [IDXW:0]         out_nz_count
);

  state_e              r_state, w_state_d;
  logic [NVEC*BW-1:0]  r_act, w_act_d;
  logic [NVEC-1:0]     r_mask, w_mask_d;
  logic [IDXW:0]       r_nz_count, w_nz_d;

  logic [NVEC-1:0]     w_in_mask;
  logic [IDXW:0]       w_in_cnt;
  logic [IDXW:0]       w_rem_cnt;
  logic [NVEC-1:0]     w_clear;
  logic                w_emit;
  logic                w_accept;
  logic [IDXW-1:0]     w_pick_idx [2];
  logic                w_pick_vld [2];
  logic [BW-1:0]       w_act_arr [NVEC];

  for (genvar i = 0; i < NVEC; i++) begin : g_unpack
    assign w_act_arr[i] = r_act[i*BW +: BW];
  end

  nz_pick2 #(
    .NVEC (NVEC),
    .IDXW (IDXW)
  ) u_pick (
    .i_mask (r_mask),
    .o_idx0 (w_pick_idx[0]),
    .o_vld0 (w_pick_vld[0]),
    .o_idx1 (w_pick_idx[1]),
    .o_vld1 (w_pick_vld[1])
  );

  // Nonzero mask/count of the incoming vector and count of remaining elements.
  always_comb begin
    w_in_mask = '0;
    w_in_cnt  = '0;
    w_rem_cnt = '0;
    for (int i = 0; i < NVEC; i++) begin
      w_in_mask[i] = (in_act[i*BW +: BW] != '0);
      w_in_cnt     = w_in_cnt + (IDXW+1)'(w_in_mask[i]);
      w_rem_cnt    = w_rem_cnt + (IDXW+1)'(r_mask[i]);
    end
  end

  always_comb begin
    w_clear = '0;
    if (w_pick_vld[0]) w_clear[w_pick_idx[0]] = 1'b1;
    if (w_pick_vld[1]) w_clear[w_pick_idx[1]] = 1'b1;
  end

  assign w_emit    = (r_state == StEmit);
  assign out_valid = w_emit;
  // An all-zero vector has nothing remaining, so its single beat is last.
  assign out_last  = w_emit && (32'(w_rem_cnt) <= LANES);
  // Next vector is taken on the final-beat handshake for zero-bubble streaming.
  assign in_ready  = !reset && (!w_emit || (out_ready && out_last));
  assign w_accept  = in_valid && in_ready;
  assign out_nz_count = r_nz_count;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    if (l < 2) begin : g_pick
      logic w_vld;
      assign w_vld = w_emit && w_pick_vld[l];
      assign out_lane_valid[l]              = w_vld;
      assign out_act_index[l*IDXW +: IDXW]  = w_vld ? w_pick_idx[l] : '0;
      assign out_activation[l*BW +: BW]     = w_vld ? w_act_arr[w_pick_idx[l]] : '0;
    end else begin : g_idle
      assign out_lane_valid[l]              = 1'b0;
      assign out_act_index[l*IDXW +: IDXW]  = '0;
      assign out_activation[l*BW +: BW]     = '0;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_act_d   = r_act;
    w_mask_d  = r_mask;
    w_nz_d    = r_nz_count;
    if (w_accept) begin
      w_state_d = StEmit;
      w_act_d   = in_act;
      w_mask_d  = w_in_mask;
      w_nz_d    = w_in_cnt;
    end else if (w_emit && out_ready) begin
      if (out_last) begin
        w_state_d = StIdle;
        w_mask_d  = '0;
      end else begin
        w_mask_d  = r_mask & ~w_clear;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_act      <= '0;
      r_mask     <= '0;
      r_nz_count <= '0;
    end else begin
      r_state    <= w_state_d;
      r_act      <= w_act_d;
      r_mask     <= w_mask_d;
      r_nz_count <= w_nz_d;
    end
  end

endmodule

// File: tb/tb_act_sparse_encoder.sv
// Scoreboard bench for act_sparse_encoder: the driver pushes the expected beat
// list of every accepted vector; an independent monitor compares and pops.
module tb_act_sparse_encoder;

  localparam int BW    = act_enc_pkg::DefBw;
  localparam int NVEC  = act_enc_pkg::DefNvec;
  localparam int LANES = act_enc_pkg::DefLanes;
  localparam int IDXW  = act_enc_pkg::DefIdxw;

  typedef struct packed {
    logic [LANES*BW-1:0]   act;
    logic [LANES*IDXW-1:0] idx;
    logic [LANES-1:0]      lv;
    logic                  last;
    logic [IDXW:0]         nz;
  } beat_t;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  out_ready = 1'b0;
  logic [NVEC*BW-1:0]    in_act = '0;
  logic                  in_ready;
  logic                  out_valid;
  logic [LANES*BW-1:0]   out_activation;
  logic [LANES*IDXW-1:0] out_act_index;
  logic [LANES-1:0]      out_lane_valid;
  logic                  out_last;
  logic [IDXW:0]         out_nz_count;

  beat_t sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  always #5 clk = ~clk;

  act_sparse_encoder dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_act         (in_act),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_activation (out_activation),
    .out_act_index  (out_act_index),
    .out_lane_valid (out_lane_valid),
    .out_last       (out_last),
    .out_nz_count   (out_nz_count)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, got, want);
    end
  endtask

  // Reference: list the nonzero positions, then chop into groups of LANES.
  task automatic push_model(input logic [NVEC*BW-1:0] a);
    int    pos[$];
    beat_t b;
    for (int i = 0; i < NVEC; i++) if (a[i*BW +: BW] != 0) pos.push_back(i);
    if (pos.size() == 0) begin
      b = '0;
      b.last = 1'b1;
      sb.push_back(b);
      return;
    end
    for (int s = 0; s < pos.size(); s += LANES) begin
      b = '0;
      b.nz = (IDXW+1)'(pos.size());
      for (int l = 0; l < LANES; l++) begin
        if (s + l < pos.size()) begin
          b.lv[l] = 1'b1;
          b.idx[l*IDXW +: IDXW] = IDXW'(pos[s+l]);
          b.act[l*BW +: BW] = a[pos[s+l]*BW +: BW];
        end
      end
      b.last = (s + LANES >= pos.size());
      sb.push_back(b);
    end
  endtask

  // One clock of stimulus; expectations are queued just after the edge.
  task automatic cyc(input logic v, input logic [NVEC*BW-1:0] a, input logic ordy,
                     input logic rst);
    logic acc;
    @(negedge clk);
    #1;
    in_valid  = v;
    in_act    = a;
    out_ready = ordy;
    reset     = rst;
    #1;
    acc = v && in_ready && !rst;
    @(posedge clk);
    #1;
    if (rst) sb.delete();
    else if (acc) push_model(a);
  endtask

  // Monitor: samples after stimulus has settled, well before the next edge.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (reset) begin
        check("in_ready_in_reset", 64'(in_ready), 64'd0);
      end else begin
        check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        check("in_ready", 64'(in_ready),
              64'(sb.size() == 0 || (out_ready && sb[0].last)));
        if (out_valid && sb.size() != 0) begin
          check("beat", 64'({out_activation, out_act_index, out_lane_valid, out_last,
                             out_nz_count}), 64'(sb[0]));
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    logic [NVEC*BW-1:0] a;
    logic v, ordy, rst;
    int k;

    repeat (3) cyc(1'b1, '1, 1'b1, 1'b1);
    check("reset_state", 64'({out_valid, out_last, out_lane_valid, out_activation,
                              out_act_index, out_nz_count}), 64'd0);

    // {0,7,0,3}: single beat.
    cyc(1'b1, {4'd0, 4'd7, 4'd0, 4'd3}, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    // {13,11,9,5}: two beats.
    cyc(1'b1, {4'd13, 4'd11, 4'd9, 4'd5}, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    // All zero.
    cyc(1'b1, 16'h0, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    // {0,8,0,0} with backpressure; in_act wiggles while not accepting.
    cyc(1'b1, {4'd0, 4'd8, 4'd0, 4'd0}, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 16'($urandom), 1'b0, 1'b0);
    cyc(1'b0, 16'($urandom), 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    // Back-to-back with in_valid held.
    cyc(1'b1, {4'd0, 4'd1, 4'd0, 4'd2}, 1'b1, 1'b0);
    cyc(1'b1, {4'd3, 4'd0, 4'd4, 4'd5}, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    // Reset between beat 1 and beat 2.
    cyc(1'b1, {4'd13, 4'd11, 4'd9, 4'd5}, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b1);
    check("post_reset_out_valid", 64'(out_valid), 64'd0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NVEC; i++)
        a[i*BW +: BW] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      v    = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 7);
      rst  = ($urandom_range(0, 99) < 2);
      cyc(v, a, ordy, rst);
    end

    k = 0;
    while (sb.size() != 0 && k < 20) begin
      cyc(1'b0, 16'h0, 1'b1, 1'b0);
      k++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
